// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg -- shared types and constants for the memory access controller.
//
// Contents:
//   DEF_ADDR_W, DEF_DATA_W   default request/SRAM address and data widths
//   DEF_WAIT_CYCLES          default strobe-active cycles per SRAM access
//   WAIT_CNT_W               width of the wait counter (covers 1..15)
//   MMIO_ADDR                word address decoded as memory-mapped I/O
//   state_t                  controller FSM state encoding
//
// Build option: MEM_ACCESS_MMIO_EN adds the MMIO state to state_t.
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int WAIT_CNT_W      = 4;

  localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3
`ifdef MEM_ACCESS_MMIO_EN
    ,
    MMIO   = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if -- request/response channel between a control unit and
// the memory access controller.
//
// Handshake: a request transfers on the rising Clk edge where req_valid and
// req_ready are both 1; req_we/req_addr/req_wdata must be stable while
// req_valid is 1 and are don't-care otherwise. There is no response
// back-pressure: rsp_valid is a single-cycle pulse and rsp_rdata is
// meaningful in that cycle after a read (it then holds until the next read).
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  controller idle, can accept
//   req_we     master->slave  1 = write, 0 = read
//   req_addr   master->slave  word address (ADDR_W)
//   req_wdata  master->slave  write data (DATA_W)
//   rsp_valid  slave->master  completion pulse
//   rsp_rdata  slave->master  read data (DATA_W)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mmio_regs.sv
// ---------------------------------------------------------------------------
// mmio_regs -- memory-mapped I/O registers of the memory access controller.
//
// Only built with MEM_ACCESS_MMIO_EN; without it the controller has no MMIO
// and this file contributes nothing.
//
// Ports:
//   Clk, Reset_n  clock, asynchronous active-low reset
//   wr_en         write strobe (one cycle, on the accept edge)
//   wdata         data written to HEX_reg
//   Switches      board switch inputs
//   HEX_reg       registered display value, cleared by reset
//   rd_data       read mux result (the switch inputs)
// ---------------------------------------------------------------------------
`ifdef MEM_ACCESS_MMIO_EN
module mmio_regs (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        wr_en,
  input  logic [15:0] wdata,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_reg,
  output logic [15:0] rd_data
);

  logic [15:0] hex_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hex_q <= '0;
    end else if (wr_en) begin
      hex_q <= wdata;
    end
  end

  assign HEX_reg = hex_q;
  // Single readable location: the switches.
  assign rd_data = Switches;

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl -- turns single-word requests into timed, active-low
// asynchronous SRAM strobe sequences.
//
// SRAM access: IDLE -> SETUP (1) -> ACCESS (WAIT_CYCLES) -> HOLD (1) -> IDLE.
// rsp_valid pulses in HOLD, i.e. WAIT_CYCLES+2 cycles after the accept edge.
//
// Parameters: WAIT_CYCLES (1..15), ADDR_W, DATA_W (must match bus instance).
//
// Ports:
//   Clk, Reset_n         clock, asynchronous active-low reset
//   bus                  request/response channel (slave modport)
//   Mem_CE/UB/LB/OE/WE   SRAM strobes, active-low
//   Mem_ADDR             SRAM address
//   Mem_DQ_out/Mem_DQ_oe SRAM data out and its output enable
//   Mem_DQ_in            SRAM data in
//   Switches, HEX_reg    memory-mapped I/O (HEX_reg is 0 without MMIO)
//   dbg_state            current FSM state
//
// Build option: MEM_ACCESS_MMIO_EN maps address 16'hFFFF to MMIO (read =
// Switches, write = HEX_reg) with a one-cycle MMIO state and no SRAM strobes.
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  mem_access_ctrl_if.slave  bus,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_DQ_out,
  output logic              Mem_DQ_oe,
  input  logic [DATA_W-1:0] Mem_DQ_in,
  input  logic [15:0]       Switches,
  output logic [15:0]       HEX_reg,
  output state_t            dbg_state
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("mem_access_ctrl: WAIT_CYCLES must be within 1..15");
    end
  endgenerate

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rsp_rdata_q;
  logic                    accept;
  logic                    access_last;
  logic                    is_mmio;

  assign accept      = bus.req_valid && bus.req_ready;
  assign access_last = (state_q == ACCESS) && (wait_cnt_q == WAIT_LAST);

`ifdef MEM_ACCESS_MMIO_EN
  logic        mmio_wr;
  logic [15:0] mmio_rdata;

  assign is_mmio = (bus.req_addr == ADDR_W'(MMIO_ADDR));
  // HEX_reg takes the request data directly on the accept edge.
  assign mmio_wr = accept && is_mmio && bus.req_we;

  mmio_regs u_mmio_regs (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .wr_en    (mmio_wr),
    .wdata    (16'(bus.req_wdata)),
    .Switches (Switches),
    .HEX_reg  (HEX_reg),
    .rd_data  (mmio_rdata)
  );
`else
  logic unused_switches;

  assign is_mmio         = 1'b0;
  assign HEX_reg         = '0;
  assign unused_switches = ^Switches;
`endif

  // State, wait counter, request capture and read data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;

      // Counts ACCESS cycles; returns to 0 on the last one so it is ready
      // for the next access without an extra clear.
      if ((state_q == ACCESS) && (wait_cnt_q != WAIT_LAST)) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end

      // Registered copy isolates the access from later input changes.
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end

      if (access_last && !we_q) begin
        rsp_rdata_q <= Mem_DQ_in;
      end
`ifdef MEM_ACCESS_MMIO_EN
      // MMIO read data must be ready during the single MMIO cycle, so it is
      // captured on the accept edge.
      if (accept && is_mmio && !bus.req_we) begin
        rsp_rdata_q <= DATA_W'(mmio_rdata);
      end
`endif
    end
  end

  // Next state and strobes.
  always_comb begin
    state_d       = state_q;
    Mem_CE        = 1'b1;
    Mem_UB        = 1'b1;
    Mem_LB        = 1'b1;
    Mem_OE        = 1'b1;
    Mem_WE        = 1'b1;
    Mem_DQ_oe     = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
`ifdef MEM_ACCESS_MMIO_EN
          state_d = is_mmio ? MMIO : SETUP;
`else
          state_d = SETUP;
`endif
        end
      end
      SETUP: begin
        Mem_CE    = 1'b0;
        Mem_UB    = 1'b0;
        Mem_LB    = 1'b0;
        Mem_DQ_oe = we_q;
        state_d   = ACCESS;
      end
      ACCESS: begin
        Mem_CE    = 1'b0;
        Mem_UB    = 1'b0;
        Mem_LB    = 1'b0;
        Mem_DQ_oe = we_q;
        // OE and WE derive from opposite polarities of we_q, so they can
        // never be low together.
        Mem_OE    = we_q;
        Mem_WE    = !we_q;
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        Mem_CE        = 1'b0;
        Mem_UB        = 1'b0;
        Mem_LB        = 1'b0;
        Mem_DQ_oe     = we_q;
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
`ifdef MEM_ACCESS_MMIO_EN
      MMIO: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Mem_ADDR      = addr_q;
  assign Mem_DQ_out    = wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state_q;

  // is_mmio only steers the FSM when MMIO is built in.
  logic unused_is_mmio;
  assign unused_is_mmio = is_mmio;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2; SRAM strobe-active cycles per access; legal range 1..15; 0 SHALL fail elaboration.
REQ-002 Parameter ADDR_W, default 16; request and SRAM address width.
REQ-003 Parameter DATA_W, default 16; data width.
REQ-004 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  control unit requests one memory access.
REQ-007 req_ready  out  1  controller can accept a request this cycle.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  word address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse for reads and writes.
REQ-012 rsp_rdata  out  DATA_W  read data; valid when rsp_valid is high after a read.
REQ-013 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.
REQ-014 Mem_ADDR  out  ADDR_W; Mem_DQ_out  out  DATA_W; Mem_DQ_oe  out  1 (1 = drive bus); Mem_DQ_in  in  DATA_W.
REQ-015 Switches  in  16; HEX_reg  out  16  memory-mapped I/O.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD, MMIO.
REQ-017 req_ready SHALL be 1 only in IDLE; accept occurs on the edge where req_valid and req_ready are both 1.
REQ-018 On accept, req_we, req_addr and req_wdata SHALL be registered; later input changes have no effect on the access in flight.
REQ-019 Non-MMIO accept: IDLE->SETUP (1 cycle) ->ACCESS (exactly WAIT_CYCLES cycles, wait counter) ->HOLD (1 cycle) ->IDLE.
REQ-020 From SETUP through HOLD: Mem_CE, Mem_UB and Mem_LB are 0, and Mem_ADDR holds the registered address. In IDLE and MMIO all strobes are 1.
REQ-021 Read: Mem_OE = 0 during ACCESS; Mem_DQ_in is captured into rsp_rdata on the last ACCESS edge.
REQ-022 Write: Mem_WE = 0 during ACCESS only; Mem_DQ_oe = 1 and Mem_DQ_out = registered data from SETUP through HOLD.
REQ-023 Mem_OE and Mem_WE SHALL never be 0 in the same cycle.
REQ-024 rsp_valid SHALL be 1 only in HOLD or MMIO, for one cycle, so SRAM latency = WAIT_CYCLES+2 cycles after the accept edge.
REQ-025 rsp_rdata SHALL hold its value until the next read completes; writes leave it unchanged.
REQ-026 Back-to-back: the earliest next accept is the IDLE cycle after HOLD or MMIO; a request held high is accepted then.

Reset
REQ-027 Reset_n = 0 SHALL immediately force: state IDLE; strobes 1; Mem_DQ_oe 0; rsp_valid 0; rsp_rdata 0; HEX_reg 0; wait counter 0.
REQ-028 Reset mid-access SHALL abort the access with no rsp_valid; the first accept is allowed on the first edge after Reset_n returns to 1.

Configuration
REQ-029 Macro MEM_ACCESS_MMIO_EN defined: address 16'hFFFF goes IDLE->MMIO->IDLE with no SRAM strobes.
  - MMIO read: rsp_rdata = Switches.
  - MMIO write: HEX_reg = wdata.
  - rsp_valid is asserted in the MMIO cycle (latency 1).
REQ-030 Macro undefined: 16'hFFFF is an ordinary SRAM address, the MMIO state is absent, and HEX_reg is tied to 0.

Structure
REQ-031 Package mem_pkg SHALL hold the FSM state enum, MMIO_ADDR = 16'hFFFF, and the default width and wait constants.
REQ-032 Sub-module mmio_regs (HEX_reg register plus Switches read mux) SHALL be instantiated only under MEM_ACCESS_MMIO_EN.

Verification
REQ-033 Read, WAIT_CYCLES=2, addr 16'h0010, Mem_DQ_in = 16'hBEEF -> Mem_OE low 2 cycles; rsp_valid on cycle 4 after accept; rsp_rdata = 16'hBEEF.
REQ-034 Write addr 16'h0020, data 16'h1234 -> Mem_WE low 2 cycles; Mem_DQ_oe high SETUP..HOLD with Mem_DQ_out = 16'h1234; rsp_rdata unchanged.
REQ-035 req_valid held high for two reads -> second accept on the cycle after the first HOLD; two rsp_valid pulses 5 cycles apart.
REQ-036 Reset_n pulsed low during the ACCESS phase of a write -> Mem_WE and Mem_CE go to 1 at once; no rsp_valid; the next request completes normally.
REQ-037 With MEM_ACCESS_MMIO_EN, write 16'hFFFF = 16'h00A5, then read it with Switches = 16'h0F0F -> HEX_reg = 16'h00A5; read returns 16'h0F0F; each rsp_valid 1 cycle after accept; Mem_CE stays 1.
